uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; the counterpart of the transmitter on the same oversampled clock domain.
- Samples the asynchronous RsRx line at OVERSAMPLE x baud and detects 8N1 frames (1 start, 8 data LSB-first, 1 stop).
- Presents each received byte to the downstream consumer (command parser / loopback into the transmitter) via a valid/ready handshake with a one-entry holding register.
- Reports framing and overrun errors.

Parameters:
OVERSAMPLE, 16, samples per bit; power of two, >= 8; mid-bit index MID = OVERSAMPLE/2 - 1

Ports:
uart_samplig_clk  input  1  oversampling clock (OVERSAMPLE x baud)
reset  input  1  synchronous, active-low
RsRx  input  1  asynchronous serial line, idle high
data_out  output  8  received byte, stable while valid=1
valid  output  1  data_out holds an unconsumed byte
ready  input  1  consumer accepts; transfer when valid && ready at clock edge
frame_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: byte completed while holding register full and not drained
clear_errors  input  1  synchronous clear of overrun

Behaviour:
- Reset is synchronous on uart_samplig_clk, active-low (reset==0). State->IDLE; data_out=8'h00; valid=0; frame_error=0; overrun=0; both sync flops=1; phase=0; bit count=0.
- Input sync: 2-flop synchronizer; rx_s = second flop. Only rx_s is used by the FSM.
- phase counter: log2(OVERSAMPLE) bits, wraps naturally at OVERSAMPLE-1 -> 0.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: rx_s==0 -> START, phase<=0.
- START: phase++ each cycle. At phase==MID: rx_s==0 -> DATA, phase<=0, bit count<=0; rx_s==1 -> IDLE (glitch rejected, no error, no output).
- DATA: phase++. At phase==OVERSAMPLE-1: shift register <= {rx_s, shreg[7:1]} (LSB first), bit count++. After the 8th sample -> STOP, phase<=0.
- STOP: phase++. At phase==OVERSAMPLE-1:
  - rx_s==1 -> deliver byte, go to IDLE.
  - rx_s==0 -> frame_error=1 for exactly one cycle, byte discarded, go to BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. No new frame is detected while the line stays low.
- Latency (OVERSAMPLE=16): if RsRx is first sampled low at edge t0, bit n is sampled at edge t0+26+16n and valid is high from edge t0+154.
- Every bit is sampled at its centre (start edge + 24 + 16n samples). Accepts back-to-back frames: the next start edge is detected from the second half of the stop bit.
- Deliver, holding register empty, or drained (valid && ready) in the same cycle: data_out<=byte, valid<=1.
- Deliver while valid && !ready: keep old data_out and valid; overrun<=1; new byte dropped.
- valid && ready with no deliver: valid<=0. data_out keeps its last value.
- clear_errors: overrun<=0. If an overrun event occurs in the same cycle, set wins.
- Reset mid-frame: immediate return to IDLE; any partial byte and a held byte are discarded.

Test Plan:
- Send 8'hA5 as ideal 8N1 frame at 16 samples/bit, ready=1 -> data_out=8'hA5, valid high exactly one cycle at t0+154, frame_error=0, overrun=0.
- Low glitch of 4 samples on idle line -> FSM returns to IDLE at phase MID, no valid. A following frame 8'h3C is received correctly.
- Frame 8'h55 with stop bit forced low, line then held low 40 bit-times -> one frame_error pulse, valid stays 0, no further frames detected until the line returns high. Next frame 8'h0F is received correctly.
- ready=0; send 8'h11 then 8'h22 back-to-back -> data_out stays 8'h11, valid=1, overrun=1. Then pulse ready -> valid=0. Pulse clear_errors -> overrun=0.
- ready=1 throughout; send 8'h00, 8'hFF, 8'h81 back-to-back (stop bit immediately followed by start) -> three valid pulses with correct bytes, no errors.
- Drive reset low mid-DATA of frame 8'hC3 -> all outputs at reset values the next cycle. After release, the remainder of the frame produces no spurious valid and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage on the oversampled clock: synchronizes RsRx, samples each bit at
// its centre and hands bytes to the consumer through a one-entry valid/ready holding register.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       uart_samplig_clk,
    input  logic       reset,
    input  logic       RsRx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overrun,
    input  logic       clear_errors
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] MID  = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] LAST = PW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    state_t        next_state;
    logic          rx_meta;
    logic          rx_s;
    logic [PW-1:0] phase;
    logic [2:0]    bit_count;
    logic [7:0]    shreg;
    logic          phase_clear;
    logic          shift_en;
    logic          deliver;
    logic          stop_bad;

    // Sync flops reset to the idle (high) line level so no false start follows reset.
    always_ff @(posedge uart_samplig_clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RsRx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge uart_samplig_clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_s) next_state = START;
            START:   if (phase == MID) next_state = rx_s ? IDLE : DATA;
            DATA:    if (phase == LAST && bit_count == 3'd7) next_state = STOP;
            STOP:    if (phase == LAST) next_state = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        phase_clear = 1'b0;
        shift_en    = 1'b0;
        deliver     = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            IDLE:    phase_clear = 1'b1;
            START:   phase_clear = (phase == MID) && !rx_s;
            DATA:    shift_en    = (phase == LAST);
            STOP: begin
                deliver  = (phase == LAST) && rx_s;
                stop_bad = (phase == LAST) && !rx_s;
            end
            BREAK:   phase_clear = 1'b1;
            default: phase_clear = 1'b1;
        endcase
    end

    // Phase wraps naturally at the end of each bit, so DATA and STOP need no explicit clear.
    always_ff @(posedge uart_samplig_clk) begin
        if (!reset) begin
            phase     <= '0;
            bit_count <= 3'd0;
            shreg     <= 8'h00;
        end else begin
            phase <= phase_clear ? '0 : phase + 1'b1;
            if (state != DATA) begin
                bit_count <= 3'd0;
            end else if (shift_en) begin
                bit_count <= bit_count + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    // A byte arriving while the held byte is not being drained is dropped and flagged.
    always_ff @(posedge uart_samplig_clk) begin
        if (!reset) begin
            data_out    <= 8'h00;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= stop_bad;
            if (deliver && (!valid || ready)) begin
                data_out <= shreg;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (deliver && valid && !ready) begin
                overrun <= 1'b1;
            end else if (clear_errors) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level reference model driven by the bench's
// own transmit schedule, compared against the DUT outputs every cycle.
module tb_uart_receiver;

    localparam int OS  = 16;
    localparam int LAT = 154;

    typedef struct {
        int         t;
        bit         isErr;
        logic [7:0] b;
    } ev_t;

    logic       uart_samplig_clk = 1'b0;
    logic       reset = 1'b0;
    logic       RsRx = 1'b1;
    logic       ready = 1'b1;
    logic       clear_errors = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_error;
    logic       overrun;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .uart_samplig_clk(uart_samplig_clk),
        .reset(reset),
        .RsRx(RsRx),
        .data_out(data_out),
        .valid(valid),
        .ready(ready),
        .frame_error(frame_error),
        .overrun(overrun),
        .clear_errors(clear_errors)
    );

    always #5 uart_samplig_clk = ~uart_samplig_clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         lastT0 = 0;
    bit         checkEn = 1'b0;
    bit         randOn = 1'b0;
    ev_t        evq[$];
    logic [7:0] mData = 8'h00;
    logic       mValid = 1'b0;
    logic       mFe = 1'b0;
    logic       mOvr = 1'b0;
    logic       prevValid = 1'b0;
    int         riseCyc = -1;
    int         riseCount = 0;
    int         feCount = 0;
    logic [7:0] riseLog[$];
    logic [9:0] frameBits;
    bit         rGood;
    logic [7:0] rByte;
    int         rGap;

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [7:0] byteAt(int idx);
        if (idx < 0 || idx >= riseLog.size()) return 8'hxx;
        return riseLog[idx];
    endfunction

    // Each scheduled frame resolves to a single event 154 edges after its first low sample.
    always @(posedge uart_samplig_clk) begin
        bit         dlv;
        bit         ferr;
        logic [7:0] b;
        cyc++;
        dlv  = 1'b0;
        ferr = 1'b0;
        b    = 8'h00;
        if (evq.size() > 0 && evq[0].t == cyc) begin
            dlv  = !evq[0].isErr;
            ferr = evq[0].isErr;
            b    = evq[0].b;
            void'(evq.pop_front());
        end
        if (!reset) begin
            mData  = 8'h00;
            mValid = 1'b0;
            mFe    = 1'b0;
            mOvr   = 1'b0;
            evq.delete();
        end else begin
            mFe = ferr;
            if (dlv && mValid && !ready) begin
                mOvr = 1'b1;
            end else if (clear_errors) begin
                mOvr = 1'b0;
            end
            if (dlv && (!mValid || ready)) begin
                mData  = b;
                mValid = 1'b1;
            end else if (mValid && ready) begin
                mValid = 1'b0;
            end
        end
    end

    always @(negedge uart_samplig_clk) begin
        if (checkEn) begin
            checkOutput("valid", valid, mValid);
            checkOutput("data_out", data_out, mData);
            checkOutput("frame_error", frame_error, mFe);
            checkOutput("overrun", overrun, mOvr);
            if (valid === 1'b1 && prevValid !== 1'b1) begin
                riseCyc = cyc;
                riseCount++;
                riseLog.push_back(data_out);
            end
            if (frame_error === 1'b1) feCount++;
            prevValid = valid;
        end
    end

    task automatic holdLine(logic v, int samples);
        RsRx = v;
        repeat (samples) @(posedge uart_samplig_clk);
        #1;
    endtask

    task automatic idleBits(int n);
        holdLine(1'b1, n * OS);
    endtask

    // Called #1 after an edge; the next edge is the first one to see the start bit.
    task automatic applyStimulus(logic [7:0] b, logic stopBit);
        ev_t e;
        lastT0  = cyc + 1;
        e.t     = lastT0 + LAT;
        e.isErr = !stopBit;
        e.b     = b;
        evq.push_back(e);
        holdLine(1'b0, OS);
        for (int i = 0; i < 8; i++) holdLine(b[i], OS);
        holdLine(stopBit, OS);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        @(posedge uart_samplig_clk);
        #1;
        checkEn = 1'b1;
        @(posedge uart_samplig_clk);
        #1;
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_data", data_out, 8'h00);
        checkOutput("rst_fe", frame_error, 0);
        checkOutput("rst_ovr", overrun, 0);
        reset = 1'b1;
        idleBits(1);

        applyStimulus(8'hA5, 1'b1);
        idleBits(1);
        checkOutput("a5_rise_cycle", riseCyc, lastT0 + 154);
        checkOutput("a5_data", byteAt(0), 8'hA5);
        checkOutput("a5_count", riseCount, 1);
        checkOutput("a5_no_fe", feCount, 0);

        holdLine(1'b0, 4);
        idleBits(2);
        checkOutput("glitch_no_valid", riseCount, 1);
        applyStimulus(8'h3C, 1'b1);
        idleBits(1);
        checkOutput("3c_data", byteAt(1), 8'h3C);

        applyStimulus(8'h55, 1'b0);
        holdLine(1'b0, 40 * OS);
        checkOutput("break_fe_count", feCount, 1);
        checkOutput("break_no_valid", riseCount, 2);
        idleBits(2);
        applyStimulus(8'h0F, 1'b1);
        idleBits(1);
        checkOutput("0f_data", byteAt(2), 8'h0F);
        checkOutput("0f_fe_count", feCount, 1);

        ready = 1'b0;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        idleBits(1);
        checkOutput("ovr_data", data_out, 8'h11);
        checkOutput("ovr_valid", valid, 1);
        checkOutput("ovr_flag", overrun, 1);
        ready = 1'b1;
        @(posedge uart_samplig_clk);
        #1;
        ready = 1'b0;
        checkOutput("ovr_drained", valid, 0);
        checkOutput("ovr_sticky", overrun, 1);
        clear_errors = 1'b1;
        @(posedge uart_samplig_clk);
        #1;
        clear_errors = 1'b0;
        checkOutput("ovr_cleared", overrun, 0);
        checkOutput("ovr_data_kept", data_out, 8'h11);
        ready = 1'b1;

        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h81, 1'b1);
        idleBits(1);
        checkOutput("b2b_count", riseCount, 7);
        checkOutput("b2b_byte0", byteAt(4), 8'h00);
        checkOutput("b2b_byte1", byteAt(5), 8'hFF);
        checkOutput("b2b_byte2", byteAt(6), 8'h81);

        ready = 1'b0;
        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'h66, 1'b1);
        frameBits = {1'b1, 8'hC3, 1'b0};
        for (int s = 0; s < 160; s++) begin
            RsRx  = frameBits[s / 16];
            reset = !(s >= 56 && s < 120);
            if (s == 57) begin
                checkOutput("midrst_valid", valid, 0);
                checkOutput("midrst_data", data_out, 8'h00);
                checkOutput("midrst_ovr", overrun, 0);
                checkOutput("midrst_fe", frame_error, 0);
            end
            @(posedge uart_samplig_clk);
            #1;
        end
        ready = 1'b1;
        idleBits(1);
        checkOutput("midrst_no_spurious", riseCount, 8);
        applyStimulus(8'h96, 1'b1);
        idleBits(1);
        checkOutput("post_rst_data", byteAt(8), 8'h96);

        // Random frames, gaps, stop errors, ready back-pressure and error clears.
        randOn = 1'b1;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    rGood = ($urandom_range(0, 5) != 0);
                    rByte = 8'($urandom);
                    applyStimulus(rByte, rGood);
                    rGap = rGood ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 4));
                    if (rGap > 0) idleBits(rGap);
                end
                randOn = 1'b0;
            end
            begin
                while (randOn) begin
                    ready        = ($urandom_range(0, 3) != 0);
                    clear_errors = ($urandom_range(0, 15) == 0);
                    @(posedge uart_samplig_clk);
                    #1;
                end
            end
        join
        ready        = 1'b1;
        clear_errors = 1'b0;
        idleBits(2);
        checkOutput("events_drained", evq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
